// File: rtl/mem_port_arbiter.sv
// Round-robin arbiter sharing one data-memory port between the CPU
// load/store path (port 0) and the program/debug loader (port 1).
// Ports:
//   clk, reset          rising-edge clock, async active-high reset
//   rN_req/we/addr/     request bundle per port, held until rN_done
//   rN_wdata/wmask
//   rN_done/err/rdata   completion pulse, timeout flag, load data
//   cpu_stall           port 0 busy, freezes the PC register
//   m_en/we/addr/       memory strobe and registered request
//   m_wdata/wmask
//   m_rdata/m_ack       memory read data and single-cycle completion
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 16
) (
   input  logic                clk,
   input  logic                reset,
   input  logic                r0_req,
   input  logic                r0_we,
   input  logic [ADDR_W-1:0]   r0_addr,
   input  logic [DATA_W-1:0]   r0_wdata,
   input  logic [DATA_W/8-1:0] r0_wmask,
   input  logic                r1_req,
   input  logic                r1_we,
   input  logic [ADDR_W-1:0]   r1_addr,
   input  logic [DATA_W-1:0]   r1_wdata,
   input  logic [DATA_W/8-1:0] r1_wmask,
   output logic                r0_done,
   output logic                r0_err,
   output logic [DATA_W-1:0]   r0_rdata,
   output logic                r1_done,
   output logic                r1_err,
   output logic [DATA_W-1:0]   r1_rdata,
   output logic                cpu_stall,
   output logic                m_en,
   output logic                m_we,
   output logic [ADDR_W-1:0]   m_addr,
   output logic [DATA_W-1:0]   m_wdata,
   output logic [DATA_W/8-1:0] m_wmask,
   input  logic [DATA_W-1:0]   m_rdata,
   input  logic                m_ack
);

   localparam logic [1:0] IDLE   = 2'd0;
   localparam logic [1:0] ACCESS = 2'd1;
   localparam logic [1:0] RESP   = 2'd2;

   localparam int CNT_W = $clog2(TIMEOUT);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   logic [1:0]       state;
   logic             owner;
   logic             last_grant;
   logic             err_q;
   logic [CNT_W-1:0] cnt;
   logic             pick;

   // Contention goes to the port that did not win last time;
   // a lone requester wins outright.
   assign pick = (r0_req & r1_req) ? ~last_grant : r1_req;

   // Decoded from registered state so reset clears them at once.
   assign m_en    = (state == ACCESS);
   assign r0_done = (state == RESP) & ~owner;
   assign r1_done = (state == RESP) & owner;
   assign r0_err  = r0_done & err_q;
   assign r1_err  = r1_done & err_q;

   // Low in the done cycle so the PC advances exactly once.
   assign cpu_stall = r0_req & ~r0_done;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state      <= IDLE;
         owner      <= 1'b0;
         last_grant <= 1'b1;
         err_q      <= 1'b0;
         cnt        <= '0;
         m_we       <= 1'b0;
         m_addr     <= '0;
         m_wdata    <= '0;
         m_wmask    <= '0;
         r0_rdata   <= '0;
         r1_rdata   <= '0;
      end else begin
         unique case (state)
            IDLE: begin
               if (r0_req | r1_req) begin
                  owner      <= pick;
                  last_grant <= pick;
                  m_we       <= pick ? r1_we    : r0_we;
                  m_addr     <= pick ? r1_addr  : r0_addr;
                  m_wdata    <= pick ? r1_wdata : r0_wdata;
                  m_wmask    <= pick ? r1_wmask : r0_wmask;
                  cnt        <= '0;
                  state      <= ACCESS;
               end
            end
            ACCESS: begin
               // Ack wins over timeout on the final cycle.
               if (m_ack) begin
                  err_q <= 1'b0;
                  if (!m_we) begin
                     if (owner) r1_rdata <= m_rdata;
                     else       r0_rdata <= m_rdata;
                  end
                  state <= RESP;
               end else if (cnt == CNT_LAST) begin
                  err_q <= 1'b1;
                  state <= RESP;
               end else begin
                  cnt <= cnt + CNT_W'(1);
               end
            end
            RESP: state <= IDLE;
            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter: per-cycle vector table plus
// hand sequences for store, timeout and mid-access reset.
module tb_mem_port_arbiter;

   logic        clk = 1'b0;
   logic        reset;
   logic        r0_req, r0_we, r1_req, r1_we;
   logic [31:0] r0_addr, r1_addr, r0_wdata, r1_wdata;
   logic [3:0]  r0_wmask, r1_wmask;
   logic        r0_done, r0_err, r1_done, r1_err;
   logic [31:0] r0_rdata, r1_rdata;
   logic        cpu_stall, m_en, m_we;
   logic [31:0] m_addr, m_wdata, m_rdata;
   logic [3:0]  m_wmask;
   logic        m_ack;

   int total = 0;
   int bad   = 0;

   always #5 clk = ~clk;

   mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .TIMEOUT(16)) dut (
      .clk(clk), .reset(reset),
      .r0_req(r0_req), .r0_we(r0_we), .r0_addr(r0_addr),
      .r0_wdata(r0_wdata), .r0_wmask(r0_wmask),
      .r1_req(r1_req), .r1_we(r1_we), .r1_addr(r1_addr),
      .r1_wdata(r1_wdata), .r1_wmask(r1_wmask),
      .r0_done(r0_done), .r0_err(r0_err), .r0_rdata(r0_rdata),
      .r1_done(r1_done), .r1_err(r1_err), .r1_rdata(r1_rdata),
      .cpu_stall(cpu_stall), .m_en(m_en), .m_we(m_we),
      .m_addr(m_addr), .m_wdata(m_wdata), .m_wmask(m_wmask),
      .m_rdata(m_rdata), .m_ack(m_ack)
   );

   typedef struct {
      logic        rs, q0, we0, q1, we1, ack;
      logic [31:0] a0, a1, rd;
      logic        en, d0, d1, st;
      logic [31:0] ea, er0, er1;
   } vec_t;

   vec_t vq[$];

   function automatic vec_t mk(
      input logic rs, input logic q0, input logic we0,
      input logic [31:0] a0, input logic q1, input logic we1,
      input logic [31:0] a1, input logic ack, input logic [31:0] rd,
      input logic en, input logic d0, input logic d1, input logic st,
      input logic [31:0] ea, input logic [31:0] er0,
      input logic [31:0] er1);
      vec_t v;
      v.rs = rs; v.q0 = q0; v.we0 = we0; v.a0 = a0;
      v.q1 = q1; v.we1 = we1; v.a1 = a1; v.ack = ack; v.rd = rd;
      v.en = en; v.d0 = d0; v.d1 = d1; v.st = st;
      v.ea = ea; v.er0 = er0; v.er1 = er1;
      return v;
   endfunction

   task automatic chk(input string name, input logic [127:0] act,
                      input logic [127:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   int en_cnt;
   int stall_bad;

   initial begin
      reset = 1'b1;
      r0_req = 0; r0_we = 0; r0_addr = 0; r0_wdata = 0; r0_wmask = 0;
      r1_req = 0; r1_we = 0; r1_addr = 0; r1_wdata = 0; r1_wmask = 0;
      m_ack = 0; m_rdata = 0;

      // rs q0 we0 a0 q1 we1 a1 ack rd | en d0 d1 st ea er0 er1
      // reset state
      vq.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      // single load from port 0
      vq.push_back(mk(0,1,0,32'h100,0,0,0,0,0,
                      0,0,0,1,0,0,0));
      vq.push_back(mk(0,1,0,32'h100,0,0,0,1,32'hDEADBEEF,
                      1,0,0,1,32'h100,0,0));
      vq.push_back(mk(0,1,0,32'h100,0,0,0,0,0,
                      0,1,0,0,32'h100,32'hDEADBEEF,0));
      vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                      0,0,0,0,32'h100,32'hDEADBEEF,0));
      // reset, then continuous contention with immediate ack
      vq.push_back(mk(1,0,0,0,0,0,0,0,0, 0,0,0,0,0,0,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'hA5A5A5A5,
                      0,0,0,1,0,0,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h11111111,
                      1,0,0,1,32'h200,0,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h5A5A5A5A,
                      0,1,0,0,32'h200,32'h11111111,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'hC3C3C3C3,
                      0,0,0,1,32'h200,32'h11111111,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h22222222,
                      1,0,0,1,32'h300,32'h11111111,0));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h66666666,
                      0,0,1,1,32'h300,32'h11111111,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h77777777,
                      0,0,0,1,32'h300,32'h11111111,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h33333333,
                      1,0,0,1,32'h200,32'h11111111,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h88888888,
                      0,1,0,0,32'h200,32'h33333333,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h99999999,
                      0,0,0,1,32'h200,32'h33333333,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'h44444444,
                      1,0,0,1,32'h300,32'h33333333,32'h22222222));
      vq.push_back(mk(0,1,0,32'h200,1,0,32'h300,1,32'hBBBBBBBB,
                      0,0,1,1,32'h300,32'h33333333,32'h44444444));
      vq.push_back(mk(0,0,0,0,0,0,0,0,0,
                      0,0,0,0,32'h300,32'h33333333,32'h44444444));

      foreach (vq[i]) begin
         reset   = vq[i].rs;
         r0_req  = vq[i].q0; r0_we = vq[i].we0; r0_addr = vq[i].a0;
         r1_req  = vq[i].q1; r1_we = vq[i].we1; r1_addr = vq[i].a1;
         m_ack   = vq[i].ack; m_rdata = vq[i].rd;
         #1;
         chk($sformatf("vec%0d", i),
             {28'd0, m_en, r0_done, r1_done, cpu_stall, r0_err, r1_err,
              m_we, m_addr, r0_rdata, r1_rdata},
             {28'd0, vq[i].en, vq[i].d0, vq[i].d1, vq[i].st, 3'b000,
              vq[i].ea, vq[i].er0, vq[i].er1});
         step();
      end

      // store from port 1, ack in the sixth ACCESS cycle
      m_ack = 0; m_rdata = 32'hFEEDFACE;
      r1_req = 1; r1_we = 1; r1_addr = 32'h24;
      r1_wdata = 32'h11223344; r1_wmask = 4'b0011;
      step();
      chk("st_bus", {m_en, m_we, m_wmask, m_addr, m_wdata},
          {1'b1, 1'b1, 4'b0011, 32'h24, 32'h11223344});
      en_cnt = 0;
      for (int c = 0; c < 40 && !r1_done; c++) begin
         if (m_en) en_cnt++;
         m_ack = m_en && (en_cnt == 6);
         step();
      end
      m_ack = 0;
      chk("st_en_cycles", en_cnt, 6);
      chk("st_done", {r1_done, r1_err, r0_done, m_en}, 4'b1000);
      chk("st_rdata", r1_rdata, 32'h44444444);
      r1_req = 0; r1_we = 0; r1_wdata = 0; r1_wmask = 0;
      step();

      // port 0 load that never gets an ack
      r0_req = 1; r0_we = 0; r0_addr = 32'h40;
      en_cnt = 0; stall_bad = 0;
      step();
      for (int c = 0; c < 60 && !r0_done; c++) begin
         if (m_en) en_cnt++;
         if (!cpu_stall) stall_bad++;
         step();
      end
      chk("to_en_cycles", en_cnt, 16);
      chk("to_stall", stall_bad, 0);
      chk("to_done", {r0_done, r0_err, cpu_stall, m_en}, 4'b1100);
      chk("to_rdata", r0_rdata, 32'h33333333);
      r0_req = 0;
      step();
      m_ack = 1; m_rdata = 32'h0BADF00D;
      step();
      step();
      chk("late_ack", {m_en, r0_done, r1_done, r0_rdata},
          {3'b000, 32'h33333333});
      m_ack = 0;

      // reset two cycles into a port 1 load
      r1_req = 1; r1_we = 0; r1_addr = 32'h80;
      step();
      step();
      chk("rst_pre", {m_en, m_addr}, {1'b1, 32'h80});
      reset = 1;
      #1;
      chk("rst_async",
          {m_en, m_we, m_addr, m_wdata, m_wmask, r0_done, r1_done,
           r0_err, r1_err, r0_rdata, r1_rdata, cpu_stall},
          '0);
      step();
      chk("rst_no_done", {r0_done, r1_done, m_en}, 3'b000);
      r0_req = 1; r0_we = 0; r0_addr = 32'h500;
      r1_req = 1;
      reset = 0;
      step();
      chk("rst_first_grant", {m_en, m_addr}, {1'b1, 32'h500});
      m_ack = 1; m_rdata = 32'h12345678;
      step();
      m_ack = 0;
      chk("rst_done0", {r0_done, r1_done, r0_rdata},
          {2'b10, 32'h12345678});
      r0_req = 0; r1_req = 0;
      step();

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
